// File: rtl/uart_alu_top.sv
// uart_alu_top: UART-attached ALU. Receives 8N1 command packets on rx_i and
// either echoes the payload or returns a 32-bit little-endian word sum on tx_o.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset (0 = reset)
//   rx_i  - UART serial input, idle high
//   tx_o  - UART serial output, idle high
module uart_alu_top #(
  parameter int unsigned PRESCALE   = 35,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  localparam int unsigned BIT_CLKS  = 8 * PRESCALE;
  localparam int unsigned HALF_CLKS = 4 * PRESCALE;
  localparam int unsigned CNT_W     = $clog2(BIT_CLKS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  OP_ECHO   = 8'hEC;
  localparam logic [7:0]  OP_ADD    = 8'hAD;

  // ---------------------------------------------------------------- RX sync
  logic r_rx_s1, r_rx_s2, r_rx_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // ---------------------------------------------------------------- RX deframer
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             w_rx_tick;

  assign w_rx_tick = (r_rx_cnt == CNT_W'(BIT_CLKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_valid_nxt = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (r_rx_cnt == CNT_W'(HALF_CLKS - 1)) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_valid_nxt = r_rx_s2;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- packet controller
  typedef enum logic [2:0] {
    C_OPCODE, C_RSVD, C_LEN_LO, C_LEN_HI, C_PAYLOAD, C_RESULT
  } ctl_state_t;

  ctl_state_t  r_ctl_state, w_ctl_state_nxt;
  logic [7:0]  r_opcode, w_opcode_nxt;
  logic [7:0]  r_len_lo, w_len_lo_nxt;
  logic [15:0] r_remain, w_remain_nxt;
  logic [23:0] r_word, w_word_nxt;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [1:0]  r_res_idx, w_res_idx_nxt;
  logic        r_hdr_pend, w_hdr_pend_nxt;
  logic [15:0] w_len;
  logic        w_fifo_push;
  logic [7:0]  w_fifo_wdata;

  assign w_len = {r_rx_shift, r_len_lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctl_state <= C_OPCODE;
      r_opcode    <= '0;
      r_len_lo    <= '0;
      r_remain    <= '0;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_acc       <= '0;
      r_res_idx   <= '0;
      r_hdr_pend  <= 1'b0;
    end else begin
      r_ctl_state <= w_ctl_state_nxt;
      r_opcode    <= w_opcode_nxt;
      r_len_lo    <= w_len_lo_nxt;
      r_remain    <= w_remain_nxt;
      r_word      <= w_word_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_res_idx   <= w_res_idx_nxt;
      r_hdr_pend  <= w_hdr_pend_nxt;
    end
  end

  always_comb begin
    w_ctl_state_nxt = r_ctl_state;
    w_opcode_nxt    = r_opcode;
    w_len_lo_nxt    = r_len_lo;
    w_remain_nxt    = r_remain;
    w_word_nxt      = r_word;
    w_byte_idx_nxt  = r_byte_idx;
    w_acc_nxt       = r_acc;
    w_res_idx_nxt   = r_res_idx;
    w_hdr_pend_nxt  = r_hdr_pend;
    w_fifo_push     = 1'b0;
    w_fifo_wdata    = r_rx_shift;
    case (r_ctl_state)
      C_OPCODE: begin
        if (r_rx_valid) begin
          w_opcode_nxt    = r_rx_shift;
          w_acc_nxt       = '0;
          w_ctl_state_nxt = C_RSVD;
        end
      end
      C_RSVD: begin
        if (r_rx_valid) w_ctl_state_nxt = C_LEN_LO;
      end
      C_LEN_LO: begin
        if (r_rx_valid) begin
          w_len_lo_nxt    = r_rx_shift;
          w_ctl_state_nxt = C_LEN_HI;
        end
      end
      C_LEN_HI: begin
        if (r_rx_valid) begin
          w_byte_idx_nxt = '0;
          w_res_idx_nxt  = '0;
          // Lengths below the header size mean an empty payload.
          if (w_len <= 16'd4) begin
            w_remain_nxt    = '0;
            w_ctl_state_nxt = (r_opcode == OP_ADD) ? C_RESULT : C_OPCODE;
          end else begin
            w_remain_nxt    = w_len - 16'd4;
            w_ctl_state_nxt = C_PAYLOAD;
          end
        end
      end
      C_PAYLOAD: begin
        if (r_rx_valid) begin
          w_remain_nxt = r_remain - 16'd1;
          if (r_opcode == OP_ECHO) w_fifo_push = 1'b1;
          if (r_opcode == OP_ADD) begin
            // Low three bytes collect in r_word; the fourth completes the word.
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_word_nxt     = {r_rx_shift, r_word[23:8]};
            if (r_byte_idx == 2'd3) w_acc_nxt = r_acc + {r_rx_shift, r_word};
          end
          if (r_remain == 16'd1) begin
            w_ctl_state_nxt = (r_opcode == OP_ADD) ? C_RESULT : C_OPCODE;
          end
        end
      end
      C_RESULT: begin
        w_fifo_push   = 1'b1;
        w_fifo_wdata  = 8'(r_acc >> {r_res_idx, 3'b000});
        w_res_idx_nxt = r_res_idx + 2'd1;
        // A byte landing here is the next packet's opcode.
        if (r_rx_valid) begin
          w_opcode_nxt   = r_rx_shift;
          w_hdr_pend_nxt = 1'b1;
        end
        if (r_res_idx == 2'd3) begin
          w_acc_nxt       = '0;
          w_hdr_pend_nxt  = 1'b0;
          w_ctl_state_nxt = (r_hdr_pend || r_rx_valid) ? C_RSVD : C_OPCODE;
        end
      end
      default: w_ctl_state_nxt = C_OPCODE;
    endcase
  end

  // ---------------------------------------------------------------- TX byte FIFO
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wptr, r_rptr;
  logic           w_empty, w_full, w_fifo_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_fifo_push && !w_full) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_fifo_pop)             r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_fifo_push && !w_full) r_mem[r_wptr[PTR_W-1:0]] <= w_fifo_wdata;
  end

  // ---------------------------------------------------------------- TX serialiser
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == CNT_W'(BIT_CLKS - 1));
  assign tx_o      = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_fifo_pop     = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (!w_empty) begin
          w_fifo_pop     = 1'b1;
          w_tx_shift_nxt = r_mem[r_rptr[PTR_W-1:0]];
          w_tx_state_nxt = TX_START;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_START: begin
        if (w_tx_tick) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = r_tx_shift[0];
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_tx_tick) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_nxt       = 1'b1;
            w_tx_state_nxt = TX_STOP;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_nxt       = r_tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          w_tx_cnt_nxt = '0;
          // Back-to-back bytes: start bit follows the stop bit directly.
          if (!w_empty) begin
            w_fifo_pop     = 1'b1;
            w_tx_shift_nxt = r_mem[r_rptr[PTR_W-1:0]];
            w_tx_state_nxt = TX_START;
            w_tx_nxt       = 1'b0;
          end else begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_nxt       = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// tb_uart_alu_top: drives command packets into uart_alu_top over rx_i, decodes
// tx_o bit-cell by bit-cell, and compares responses with a packet-level model.
module tb_uart_alu_top;

  // Short bit time keeps the run brief; all timing derives from it.
  localparam int unsigned TB_PRESCALE = 4;
  localparam int unsigned BIT  = 8 * TB_PRESCALE;
  localparam int unsigned BYTE = 10 * BIT;

  logic clk = 1'b0;
  logic rst;
  logic rx_i;
  logic tx_o;

  always #5 clk = ~clk;

  uart_alu_top #(.PRESCALE(TB_PRESCALE), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         mon_bad = 0;
  bit         mon_busy = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Line monitor: every cell must hold one level for exactly BIT clocks.
  initial begin
    logic [9:0] v;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        v = '0;
        for (int c = 0; c < 10; c++) begin
          for (int k = 0; k < int'(BIT); k++) begin
            if (!(c == 0 && k == 0)) @(negedge clk);
            if (k == 0) v[c] = tx_o;
            else if (tx_o !== v[c]) mon_bad++;
          end
        end
        if (v[0] !== 1'b0 || v[9] !== 1'b1) mon_bad++;
        got_q.push_back(v[8:1]);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_i = 1'b1;
  endtask

  // Response predicted from packet rules: echo payload, or sum of whole LE words.
  task automatic model_pkt();
    int unsigned len, plen;
    logic [31:0] sum;
    exp_q.delete();
    len  = {pkt_q[3], pkt_q[2]};
    plen = (len < 4) ? 0 : len - 4;
    if (pkt_q[0] == 8'hEC) begin
      for (int unsigned i = 0; i < plen; i++) exp_q.push_back(pkt_q[4+i]);
    end else if (pkt_q[0] == 8'hAD) begin
      sum = 32'd0;
      for (int unsigned w = 0; w < plen / 4; w++)
        sum = sum + {pkt_q[4+4*w+3], pkt_q[4+4*w+2], pkt_q[4+4*w+1], pkt_q[4+4*w]};
      for (int b = 0; b < 4; b++) exp_q.push_back(sum[8*b +: 8]);
    end
  endtask

  task automatic run_packet(input string tag, input bit gaps);
    int t;
    model_pkt();
    got_q.delete();
    mon_bad = 0;
    foreach (pkt_q[i]) begin
      send_byte(pkt_q[i], 1'b1);
      if (gaps) repeat ($urandom_range(0, 1) * BIT) @(negedge clk);
    end
    t = 0;
    while (got_q.size() < exp_q.size() && t < int'((exp_q.size() + 4) * BYTE * 2)) begin
      @(negedge clk);
      t++;
    end
    repeat (BYTE + 20) @(negedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_cells"}, 32'(mon_bad), 32'd0);
    chk({tag, "_idle"}, 32'(mon_busy), 32'd0);
  endtask

  initial begin
    int unsigned sel, plen;
    logic [7:0]  op;
    int          low_seen;
    int          t;

    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_tx", 32'(tx_o), 32'd1);
    rst = 1'b1;
    low_seen = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low_seen++;
    end
    chk("reset_quiet", 32'(low_seen), 32'd0);
    chk("reset_nobytes", 32'(got_q.size()), 32'd0);

    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    run_packet("echo", 1'b0);

    pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
    run_packet("add", 1'b0);

    pkt_q = '{8'hAD, 8'h00, 8'h0D, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h55};
    run_packet("add_wrap", 1'b0);

    pkt_q = '{8'h77, 8'h00, 8'h05, 8'h00, 8'h99};
    run_packet("unknown", 1'b0);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_packet("echo_after_unknown", 1'b0);

    pkt_q = '{8'hAD, 8'h00, 8'h02, 8'h00};
    run_packet("add_short_len", 1'b0);
    pkt_q = '{8'hEC, 8'h00, 8'h03, 8'h00};
    run_packet("echo_short_len", 1'b0);

    // Reset partway through an ADD32 packet; the partial packet must vanish.
    pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pkt_tx", 32'(tx_o), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h3C};
    run_packet("rst_recover", 1'b0);

    // Reset while a byte of zeros is on the wire: the line must rise at once.
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h00};
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    t = 0;
    while (tx_o !== 1'b0 && t < int'(4 * BYTE)) begin
      @(negedge clk);
      t++;
    end
    repeat (2 * BIT) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx_o), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (BYTE + BIT) @(negedge clk);
    got_q.delete();
    mon_bad = 0;
    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hC3, 8'h81};
    run_packet("rst_tx_recover", 1'b0);

    // Bad stop bit on a would-be opcode, then a clean echo packet.
    send_byte(8'hEC, 1'b0);
    repeat (BIT) @(negedge clk);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hA5};
    run_packet("frame_error", 1'b0);

    for (int r = 0; r < 6; r++) begin
      sel  = $urandom_range(0, 2);
      plen = $urandom_range(0, 9);
      op   = (sel == 0) ? 8'hEC : (sel == 1) ? 8'hAD : 8'(8'h10 + $urandom_range(0, 8'h7F));
      pkt_q = '{op, 8'($urandom), 8'(plen + 4), 8'h00};
      for (int unsigned i = 0; i < plen; i++) pkt_q.push_back(8'($urandom));
      run_packet($sformatf("rand%0d_op%02h", r, op), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
